// File: rtl/gpio_cfg_loader.sv
// Loads the user-project pad configuration chain: fetches one word per pad from the
// config store, shifts it out MSB first on serial_clock/serial_data, then strobes serial_load.
module gpio_cfg_loader #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 4
) (
    input  logic                        clock,
    input  logic                        resetb,
    input  logic                        start,
    input  logic                        abort,
    output logic                        cfg_req_valid,
    output logic [$clog2(NUM_PADS)-1:0] cfg_req_idx,
    input  logic                        cfg_rsp_valid,
    input  logic [CFG_BITS-1:0]         cfg_rsp_data,
    output logic                        serial_clock,
    output logic                        serial_data,
    output logic                        serial_load,
    output logic                        busy,
    output logic                        done
);

    localparam int IDX_W = $clog2(NUM_PADS);
    localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int PH_W  = $clog2(CLK_DIV + 1);

    localparam logic [IDX_W-1:0] LAST_PAD = IDX_W'(NUM_PADS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CFG_BITS - 1);
    localparam logic [PH_W-1:0]  PH_LOAD  = PH_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LOAD,
        S_DONE
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    pad_idx;
    logic [BIT_W-1:0]    bit_cnt;
    logic [PH_W-1:0]     phase;
    logic [CFG_BITS-1:0] shreg;
    logic [CFG_BITS-1:0] shreg_shl;
    logic                phase_end;

    assign phase_end   = (phase == '0);
    assign shreg_shl   = shreg << 1;
    assign cfg_req_idx = pad_idx;

    // Outputs are assigned together with the state they belong to, so every
    // pin toward the pad ring comes straight from a flop.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state         <= S_IDLE;
            pad_idx       <= '0;
            bit_cnt       <= '0;
            phase         <= '0;
            shreg         <= '0;
            cfg_req_valid <= 1'b0;
            serial_clock  <= 1'b0;
            serial_data   <= 1'b0;
            serial_load   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else if (abort) begin
            // Leaves the chain unlatched; a later start reloads everything.
            state         <= S_IDLE;
            cfg_req_valid <= 1'b0;
            serial_clock  <= 1'b0;
            serial_data   <= 1'b0;
            serial_load   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state         <= S_FETCH;
                        pad_idx       <= LAST_PAD;
                        phase         <= PH_LOAD;
                        cfg_req_valid <= 1'b1;
                        busy          <= 1'b1;
                    end
                end

                S_FETCH: begin
                    if (cfg_rsp_valid) begin
                        state         <= S_SHIFT_LO;
                        shreg         <= cfg_rsp_data;
                        bit_cnt       <= LAST_BIT;
                        phase         <= PH_LOAD;
                        cfg_req_valid <= 1'b0;
                        serial_data   <= cfg_rsp_data[CFG_BITS-1];
                    end
                end

                S_SHIFT_LO: begin
                    if (phase_end) begin
                        state        <= S_SHIFT_HI;
                        phase        <= PH_LOAD;
                        serial_clock <= 1'b1;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end

                S_SHIFT_HI: begin
                    if (phase_end) begin
                        shreg        <= shreg_shl;
                        phase        <= PH_LOAD;
                        serial_clock <= 1'b0;
                        if (bit_cnt != '0) begin
                            state       <= S_SHIFT_LO;
                            bit_cnt     <= bit_cnt - 1'b1;
                            serial_data <= shreg_shl[CFG_BITS-1];
                        end else if (pad_idx != '0) begin
                            state         <= S_FETCH;
                            pad_idx       <= pad_idx - 1'b1;
                            cfg_req_valid <= 1'b1;
                            serial_data   <= 1'b0;
                        end else begin
                            state       <= S_LOAD;
                            serial_data <= 1'b0;
                            serial_load <= 1'b1;
                        end
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end

                S_LOAD: begin
                    if (phase_end) begin
                        state       <= S_DONE;
                        serial_load <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state         <= S_IDLE;
                    cfg_req_valid <= 1'b0;
                    serial_clock  <= 1'b0;
                    serial_data   <= 1'b0;
                    serial_load   <= 1'b0;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Directed bench for gpio_cfg_loader: a small 2-pad/3-bit/div-1 instance and the
// default 38-pad/13-bit/div-4 instance, each with its own config-store model.
module tb_gpio_cfg_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic resetb;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Small instance: NUM_PADS=2, CFG_BITS=3, CLK_DIV=1
    logic       start_s, abort_s, req_valid_s, rsp_valid_s;
    logic [0:0] req_idx_s;
    logic [2:0] rsp_data_s;
    logic       sclk_s, sdata_s, sload_s, busy_s, done_s;

    // Default instance: NUM_PADS=38, CFG_BITS=13, CLK_DIV=4
    logic        start_l, abort_l, req_valid_l, rsp_valid_l;
    logic [5:0]  req_idx_l;
    logic [12:0] rsp_data_l;
    logic        sclk_l, sdata_l, sload_l, busy_l, done_l;

    gpio_cfg_loader #(.NUM_PADS(2), .CFG_BITS(3), .CLK_DIV(1)) dut_s (
        .clock(clock), .resetb(resetb), .start(start_s), .abort(abort_s),
        .cfg_req_valid(req_valid_s), .cfg_req_idx(req_idx_s),
        .cfg_rsp_valid(rsp_valid_s), .cfg_rsp_data(rsp_data_s),
        .serial_clock(sclk_s), .serial_data(sdata_s), .serial_load(sload_s),
        .busy(busy_s), .done(done_s)
    );

    gpio_cfg_loader #(.NUM_PADS(38), .CFG_BITS(13), .CLK_DIV(4)) dut_l (
        .clock(clock), .resetb(resetb), .start(start_l), .abort(abort_l),
        .cfg_req_valid(req_valid_l), .cfg_req_idx(req_idx_l),
        .cfg_rsp_valid(rsp_valid_l), .cfg_rsp_data(rsp_data_l),
        .serial_clock(sclk_l), .serial_data(sdata_l), .serial_load(sload_l),
        .busy(busy_l), .done(done_l)
    );

    // Config store models
    int rsp_delay_s = 0;
    int wait_s = 0;
    assign rsp_valid_s = req_valid_s && (wait_s >= rsp_delay_s);
    assign rsp_data_s  = req_idx_s[0] ? 3'b101 : 3'b011;
    always @(posedge clock) begin
        if (req_valid_s && !rsp_valid_s) wait_s <= wait_s + 1;
        else wait_s <= 0;
    end

    function automatic logic [12:0] word_l(input int i);
        return 13'((i * 797 + 3) ^ (i * 128));
    endfunction
    assign rsp_valid_l = req_valid_l;
    assign rsp_data_l  = word_l(int'(req_idx_l));

    // Small-instance monitor
    logic p_sclk_s = 0, p_load_s = 0, p_req_s = 0, p_sdata_s = 0;
    logic [0:0] p_idx_s = 0;
    int edges_s = 0, load_rise_s = 0, load_rise_cyc_s = 0, load_hi_s = 0;
    int done_cnt_s = 0, done_cyc_s = 0, unstable_s = 0, hi_chg_s = 0;
    bit bits_s[$];
    int idx_log_s[$];
    always @(negedge clock) begin
        if (sclk_s && !p_sclk_s) begin
            edges_s <= edges_s + 1;
            bits_s.push_back(sdata_s);
        end
        if (sclk_s && p_sclk_s && (sdata_s != p_sdata_s)) hi_chg_s <= hi_chg_s + 1;
        if (sload_s && !p_load_s) begin
            load_rise_s     <= load_rise_s + 1;
            load_rise_cyc_s <= cyc;
        end
        if (sload_s) load_hi_s <= load_hi_s + 1;
        if (done_s) begin
            done_cnt_s <= done_cnt_s + 1;
            done_cyc_s <= cyc;
        end
        if (req_valid_s && !p_req_s) idx_log_s.push_back(int'(req_idx_s));
        if (req_valid_s && p_req_s && (req_idx_s != p_idx_s)) unstable_s <= unstable_s + 1;
        p_sclk_s  <= sclk_s;
        p_load_s  <= sload_s;
        p_req_s   <= req_valid_s;
        p_sdata_s <= sdata_s;
        p_idx_s   <= req_idx_s;
    end

    // Default-instance monitor
    logic p_sclk_l = 0, p_load_l = 0, p_sdata_l = 0;
    int edges_l = 0, load_rise_l = 0, load_rise_cyc_l = 0, load_hi_l = 0;
    int done_cnt_l = 0, done_cyc_l = 0, hi_chg_l = 0;
    int hi_run_l = 0, hi_bad_l = 0, gap_l = 0, gap8_l = 0, gap9_l = 0;
    bit bits_l[$];
    always @(negedge clock) begin
        if (sclk_l && !p_sclk_l) begin
            edges_l <= edges_l + 1;
            bits_l.push_back(sdata_l);
            if (gap_l == 8) gap8_l <= gap8_l + 1;
            if (gap_l == 9) gap9_l <= gap9_l + 1;
            gap_l <= 1;
        end else begin
            gap_l <= gap_l + 1;
        end
        if (sclk_l) hi_run_l <= p_sclk_l ? hi_run_l + 1 : 1;
        if (!sclk_l && p_sclk_l && (hi_run_l != 4)) hi_bad_l <= hi_bad_l + 1;
        if (sclk_l && p_sclk_l && (sdata_l != p_sdata_l)) hi_chg_l <= hi_chg_l + 1;
        if (sload_l && !p_load_l) begin
            load_rise_l     <= load_rise_l + 1;
            load_rise_cyc_l <= cyc;
        end
        if (sload_l) load_hi_l <= load_hi_l + 1;
        if (done_l) begin
            done_cnt_l <= done_cnt_l + 1;
            done_cyc_l <= cyc;
        end
        p_sclk_l  <= sclk_l;
        p_load_l  <= sload_l;
        p_sdata_l <= sdata_l;
    end

    function automatic int outs_s();
        return int'({req_valid_s, req_idx_s, sclk_s, sdata_s, sload_s, busy_s, done_s});
    endfunction

    function automatic int outs_l();
        return int'({req_valid_l, req_idx_l, sclk_l, sdata_l, sload_l, busy_l, done_l});
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int s0_s = 0, s0_l = 0;

    task automatic pulse_start_s();
        @(posedge clock); #1 start_s = 1'b1;
        @(posedge clock); #1 start_s = 1'b0;
        s0_s = cyc;
    endtask

    task automatic pulse_start_l();
        @(posedge clock); #1 start_l = 1'b1;
        @(posedge clock); #1 start_l = 1'b0;
        s0_l = cyc;
    endtask

    task automatic wait_done_s(input int d0, input int limit);
        int g = 0;
        while (done_cnt_s == d0 && g < limit) begin
            @(posedge clock);
            g++;
        end
    endtask

    // Full small transfer: bitstream 1,0,1,0,1,1 and strobe/done timing.
    task automatic run_small(input string tag, input int exp_done);
        int e0 = edges_s;
        int b0 = bits_s.size();
        int d0 = done_cnt_s;
        int u0 = unstable_s;
        int i0 = idx_log_s.size();
        int h0 = load_hi_s;
        int c0 = hi_chg_s;
        int got = 0;
        pulse_start_s();
        wait_done_s(d0, 200);
        repeat (2) @(posedge clock);
        #1;
        check({tag, "_done_count"}, done_cnt_s - d0, 1);
        check({tag, "_edges"}, edges_s - e0, 6);
        for (int i = 0; i < 6; i++) got = (got << 1) | int'(bits_s[b0 + i]);
        check({tag, "_bits"}, got, 6'b101011);
        check({tag, "_done_cycle"}, done_cyc_s - s0_s + 1, exp_done);
        check({tag, "_load_cycle"}, load_rise_cyc_s - s0_s + 1, exp_done - 1);
        check({tag, "_load_len"}, load_hi_s - h0, 1);
        check({tag, "_req_count"}, idx_log_s.size() - i0, 2);
        check({tag, "_req_idx_first"}, idx_log_s[i0], 1);
        check({tag, "_req_idx_second"}, idx_log_s[i0 + 1], 0);
        check({tag, "_req_stable"}, unstable_s - u0, 0);
        check({tag, "_data_stable_hi"}, hi_chg_s - c0, 0);
        check({tag, "_idle_after"}, outs_s(), 0);
    endtask

    initial begin
        int e0, b0, d0, lr0, lh0, g8, g9, hb0, g, bad;
        logic [12:0] w;
        resetb = 1'b0;
        start_s = 1'b0; abort_s = 1'b0;
        start_l = 1'b0; abort_l = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clock);
        #1;
        check("reset_outs_s", outs_s(), 0);
        check("reset_outs_l", outs_l(), 0);
        resetb = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (outs_s() != 0 || outs_l() != 0) bad++;
        end
        check("idle_20_cycles", bad, 0);

        // Zero-wait and wait-state transfers on the small instance
        rsp_delay_s = 0;
        run_small("zero_wait", 16);
        rsp_delay_s = 3;
        run_small("wait3", 22);
        rsp_delay_s = 0;

        // start while busy (cycle 5) and in the DONE cycle (cycle 16) are both ignored
        e0 = edges_s; d0 = done_cnt_s;
        pulse_start_s();
        repeat (4) @(posedge clock);
        #1 start_s = 1'b1;
        @(posedge clock); #1 start_s = 1'b0;
        repeat (10) @(posedge clock);
        #1 start_s = 1'b1;
        @(posedge clock); #1 start_s = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("busy_start_busy", int'(busy_s), 0);
        check("busy_start_done_count", done_cnt_s - d0, 1);
        check("busy_start_edges", edges_s - e0, 6);
        check("busy_start_done_cycle", done_cyc_s - s0_s + 1, 16);
        run_small("second", 16);

        // Mid-transfer reset clears outputs asynchronously
        lr0 = load_rise_s;
        pulse_start_s();
        repeat (6) @(posedge clock);
        #3 resetb = 1'b0;
        #1;
        check("midreset_outs_s", outs_s(), 0);
        @(posedge clock); #1 resetb = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("midreset_no_load", load_rise_s - lr0, 0);
        check("midreset_idle", outs_s(), 0);

        // Default instance, zero-wait full chain
        e0 = edges_l; b0 = bits_l.size(); d0 = done_cnt_l;
        lh0 = load_hi_l; g8 = gap8_l; g9 = gap9_l; hb0 = hi_bad_l;
        check("l_first_req_idle", int'(req_valid_l), 0);
        pulse_start_l();
        #1;
        check("l_first_req_idx", int'(req_idx_l), 37);
        g = 0;
        while (done_cnt_l == d0 && g < 6000) begin
            @(posedge clock);
            g++;
        end
        repeat (2) @(posedge clock);
        #1;
        check("l_done_count", done_cnt_l - d0, 1);
        check("l_edges", edges_l - e0, 494);
        check("l_done_cycle", done_cyc_l - s0_l + 1, 3995);
        check("l_load_cycle", load_rise_cyc_l - s0_l + 1, 3991);
        check("l_load_len", load_hi_l - lh0, 4);
        check("l_hi_phase_len", hi_bad_l - hb0, 0);
        check("l_gap8", gap8_l - g8, 456);
        check("l_gap9", gap9_l - g9, 37);
        check("l_data_stable_hi", hi_chg_l, 0);
        bad = 0;
        for (int p = 37; p >= 0; p--) begin
            w = word_l(p);
            for (int b = 12; b >= 0; b--) begin
                if (bits_l[b0 + (37 - p) * 13 + (12 - b)] != w[b]) bad++;
            end
        end
        check("l_bitstream", bad, 0);
        check("l_idle_after", outs_l(), 0);

        // Abort during the 5th bit of pad 20
        e0 = edges_l; d0 = done_cnt_l; lr0 = load_rise_l;
        pulse_start_l();
        g = 0;
        while ((edges_l - e0) < 226 && g < 3000) begin
            @(negedge clock);
            g++;
        end
        check("abort_reached_bit", int'(sclk_l), 1);
        abort_l = 1'b1;
        @(posedge clock); #1 abort_l = 1'b0;
        check("abort_sclk", int'(sclk_l), 0);
        check("abort_sdata", int'(sdata_l), 0);
        check("abort_sload", int'(sload_l), 0);
        check("abort_req", int'(req_valid_l), 0);
        check("abort_busy", int'(busy_l), 0);
        repeat (100) @(posedge clock);
        #1;
        check("abort_no_done", done_cnt_l - d0, 0);
        check("abort_no_load", load_rise_l - lr0, 0);
        check("abort_edges", edges_l - e0, 226);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gpio_cfg_loader.md
Name: gpio_cfg_loader

Overview:
- Sequences the serial configuration chain that drives the per-pad control inputs of the user-project I/O pad ring: mode, oeb, inp_dis, dm, analog_* and related bits.
- On `start`, fetches one configuration word per pad from a requester-side config store through a request/response handshake.
- Shifts each word out on a bit-serial clock/data pair, then pulses a load strobe so every pad control block latches its word at the same time.
- Sits between housekeeping (the config store) and the mprj pad control chain.

Parameters:
- NUM_PADS, 38: pads in the chain; equals `MPRJ_IO_PADS`.
- CFG_BITS, 13: configuration bits per pad.
- CLK_DIV, 4: system clocks per serial_clock phase (low and high); must be ≥1.

Ports:
- clock  in  1  system clock.
- resetb  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to reload the whole chain; ignored while busy.
- abort  in  1  abandons the transfer; no load strobe is issued.
- cfg_req_valid  out  1  word request to the config store.
- cfg_req_idx  out  $clog2(NUM_PADS)  pad index being requested.
- cfg_rsp_valid  in  1  store response; may arrive in the same cycle as the request.
- cfg_rsp_data  in  CFG_BITS  configuration word for cfg_req_idx.
- serial_clock  out  1  chain shift clock.
- serial_data  out  1  chain data; stable for the whole high phase.
- serial_load  out  1  chain latch strobe.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.

Behaviour:
- Reset (asynchronous, resetb=0): state=IDLE. All outputs 0: cfg_req_valid, cfg_req_idx, serial_clock, serial_data, serial_load, busy, done. Internal counters and shift register clear.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, DONE.
- IDLE:
  - On start=1, go to FETCH with pad_idx=NUM_PADS-1.
  - The farthest pad's word is shifted first, so it ends deepest in the chain.
- FETCH:
  - cfg_req_valid=1 and cfg_req_idx=pad_idx, held until cfg_rsp_valid=1.
  - On cfg_rsp_valid, capture cfg_rsp_data into the shift register, set bit_cnt=CFG_BITS-1, go to SHIFT_LO.
  - cfg_req_valid deasserts in the cycle after capture.
  - Waiting in FETCH has no timeout.
- SHIFT_LO:
  - serial_clock=0 and serial_data=shreg[CFG_BITS-1] (MSB first).
  - Stays CLK_DIV cycles, then goes to SHIFT_HI.
- SHIFT_HI:
  - serial_clock=1 and serial_data holds its value; stays CLK_DIV cycles.
  - On exit, shift the register left by one.
  - If bit_cnt≠0: decrement bit_cnt and go to SHIFT_LO.
  - Else if pad_idx≠0: decrement pad_idx and go to FETCH.
  - Else go to LOAD.
- LOAD:
  - serial_clock=0, serial_data=0, serial_load=1 for CLK_DIV cycles, then go to DONE.
- DONE:
  - done=1 and busy=1 for one cycle, then go to IDLE.
- Total serial_clock rising edges per transfer = NUM_PADS×CFG_BITS. No other edges occur.
- Phase counter: width $clog2(CLK_DIV+1). Reloads on every state entry and never wraps.
- Zero-wait transfer length (cfg_rsp_valid asserted in the request cycle), counted from the cycle after start is sampled: NUM_PADS×(1+2×CLK_DIV×CFG_BITS) + CLK_DIV + 1 cycles. done is the last of these cycles.
- start while busy: ignored, no queueing.
- start in the same cycle as DONE: ignored, because DONE is busy.
- abort (any non-IDLE state):
  - Next cycle: IDLE with serial_clock=0, serial_data=0, serial_load=0, cfg_req_valid=0, no done pulse.
  - abort has priority over start and over every state transition.
  - A partially shifted chain is left unlatched.
- Mid-transfer reset: outputs clear asynchronously; serial_load never glitches high.
- cfg_rsp_valid outside FETCH: ignored.
- Outputs are registered, so they are glitch-free toward the pad-domain chain.

Test Plan:
- Reset and idle: hold resetb=0, then release with start=0 for 20 cycles → all outputs stay 0 and busy=0.
- Basic load, zero-wait:
  - Setup: NUM_PADS=2, CFG_BITS=3, CLK_DIV=1; store returns pad1=3'b101 and pad0=3'b011 in the request cycle.
  - Pulse start → serial_data sampled on the serial_clock rising edges is 1,0,1,0,1,1.
  - serial_load is high in cycle 15 after the start edge; done is high in cycle 16; exactly 6 rising edges.
- Wait states: same setup, but cfg_rsp_valid is delayed 3 cycles for each request → cfg_req_idx sequence is 1 then 0; the request is held stable; the bitstream is unchanged; done arrives 6 cycles later (cycle 22).
- Clock divide: CLK_DIV=4, default NUM_PADS/CFG_BITS → each serial_clock phase lasts 4 cycles; 494 rising edges; serial_load is high for 4 cycles.
- Abort: assert abort during the 5th bit of pad 20 → next cycle all serial outputs are 0, busy=0, done never pulses, serial_load never rises.
- start while busy: pulse start again mid-transfer → ignored; exactly one done pulse; edge count unchanged. A new start after IDLE runs a complete second transfer.
